// File: rtl/il1_miss_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : il1_miss_fill_ctrl
//  Description : Per-core IL1 hit/miss sequencer between the tag-compare stage
//                and the pseudo-LRU cache controller. A hit reports the hit
//                way and completes in one cycle. A miss latches the victim
//                way, requests the shared snoop bus, burst-fetches the block
//                one word at a time, writes each word and then the tag into
//                the victim way, and finally reports the victim as accessed.
//  Ports       :
//    clk, rst_n           clock / asynchronous active-low reset
//    PrRd, Address        processor fetch request and address
//    Hit, Hit_way         tag-compare result for Address
//    LRU_replacement_proc victim way from the pseudo-LRU controller
//    Blk_accessed(_vld)   way accessed, strobe for the LRU update
//    Pr_done              instruction word available
//    Bus_req, Bus_grant   snoop-bus arbitration
//    Address_Com, Mem_rd  burst word address / read strobe on the common bus
//    Mem_vld, Data_Bus_Com returned word on the common bus
//    Fill_we/way/index/word/data  data-array write port
//    Tag_we, Fill_tag     tag-array install port
//  Revision    : 1.0  initial release
// ============================================================================
module il1_miss_fill_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int WAY_W   = 2,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 24,
    parameter int OFF_W   = 4,
    parameter int WORDS   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      PrRd,
    input  logic [ADDR_W-1:0]         Address,
    input  logic                      Hit,
    input  logic [WAY_W-1:0]          Hit_way,
    input  logic [WAY_W-1:0]          LRU_replacement_proc,
    output logic [WAY_W-1:0]          Blk_accessed,
    output logic                      Blk_accessed_vld,
    output logic                      Pr_done,
    output logic                      Bus_req,
    input  logic                      Bus_grant,
    output logic [ADDR_W-1:0]         Address_Com,
    output logic                      Mem_rd,
    input  logic                      Mem_vld,
    input  logic [ADDR_W-1:0]         Data_Bus_Com,
    output logic                      Fill_we,
    output logic [WAY_W-1:0]          Fill_way,
    output logic [INDEX_W-1:0]        Fill_index,
    output logic [$clog2(WORDS)-1:0]  Fill_word,
    output logic [ADDR_W-1:0]         Fill_data,
    output logic                      Tag_we,
    output logic [TAG_W-1:0]          Fill_tag
);

    localparam int c_CNT_W = $clog2(WORDS);
    // Byte bits below the word field of a block offset
    localparam int c_BYTE_W = OFF_W - c_CNT_W;

    localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(WORDS - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_HIT_ACK = 3'd1;
    localparam logic [2:0] c_REQ     = 3'd2;
    localparam logic [2:0] c_FILL    = 3'd3;
    localparam logic [2:0] c_INSTALL = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [TAG_W-1:0]    r_tag;
    logic [INDEX_W-1:0]  r_index;
    logic [WAY_W-1:0]    r_victim;
    logic [WAY_W-1:0]    r_hit_way;
    logic                r_fill_we;
    logic [c_CNT_W-1:0]  r_fill_word;
    logic [ADDR_W-1:0]   r_fill_data;

    logic                w_req_sample;
    logic                w_fill_fire;
    logic                w_last_word;
    logic [ADDR_W-1:0]   w_burst_addr;

    // Byte-offset bits never leave the block, so they are not latched
    logic                w_unused_addr;
    assign w_unused_addr = ^Address[OFF_W-1:0];

    // A request is only looked at while idle
    assign w_req_sample = (r_state == c_IDLE) && PrRd;

    // A word is accepted only while the bus is owned; Mem_vld without the
    // grant belongs to another master and is ignored
    assign w_fill_fire  = (r_state == c_FILL) && Bus_grant && Mem_vld;
    assign w_last_word  = (r_cnt == c_LAST_WORD);

    assign w_burst_addr = {r_tag, r_index, r_cnt, {c_BYTE_W{1'b0}}};

    // ------------------------------------------------------------------
    // Next state and burst word counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (PrRd) begin
                    w_state_nxt = Hit ? c_HIT_ACK : c_REQ;
                end
            end
            c_HIT_ACK: begin
                w_state_nxt = c_IDLE;
            end
            c_REQ: begin
                if (Bus_grant) begin
                    w_state_nxt = c_FILL;
                    w_cnt_nxt   = '0;
                end
            end
            c_FILL: begin
                // Without the grant the counter is frozen so the burst
                // resumes at the same word on regrant
                if (w_fill_fire) begin
                    if (w_last_word) begin
                        w_state_nxt = c_INSTALL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            c_INSTALL: begin
                w_state_nxt = c_DONE;
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latches and registered fill write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_tag       <= '0;
            r_index     <= '0;
            r_victim    <= '0;
            r_hit_way   <= '0;
            r_fill_we   <= 1'b0;
            r_fill_word <= '0;
            r_fill_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fill_we <= w_fill_fire;

            if (w_req_sample) begin
                if (Hit) begin
                    r_hit_way <= Hit_way;
                end else begin
                    // The victim is frozen here for the whole fill, so later
                    // LRU updates cannot redirect a half-written line
                    r_tag    <= Address[ADDR_W-1 -: TAG_W];
                    r_index  <= Address[OFF_W +: INDEX_W];
                    r_victim <= LRU_replacement_proc;
                end
            end

            // Word number and data travel with the registered write enable
            if (w_fill_fire) begin
                r_fill_word <= r_cnt;
                r_fill_data <= Data_Bus_Com;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state and latches
    // ------------------------------------------------------------------
    assign Bus_req          = (r_state == c_REQ) || (r_state == c_FILL);
    assign Mem_rd           = (r_state == c_FILL) && Bus_grant;
    assign Address_Com      = Mem_rd ? w_burst_addr : '0;
    assign Tag_we           = (r_state == c_INSTALL);
    assign Blk_accessed_vld = (r_state == c_HIT_ACK) || (r_state == c_INSTALL);
    assign Pr_done          = (r_state == c_HIT_ACK) || (r_state == c_DONE);

    always_comb begin
        Blk_accessed = '0;
        if (r_state == c_HIT_ACK) begin
            Blk_accessed = r_hit_way;
        end else if (r_state == c_INSTALL) begin
            Blk_accessed = r_victim;
        end
    end

    assign Fill_we    = r_fill_we;
    assign Fill_word  = r_fill_word;
    assign Fill_data  = r_fill_data;
    assign Fill_way   = r_victim;
    assign Fill_index = r_index;
    assign Fill_tag   = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_il1_miss_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_il1_miss_fill_ctrl
//  Description : Self-checking bench for il1_miss_fill_ctrl. A table of
//                hit/miss transactions with their expected way and latency is
//                replayed; fill writes and burst addresses are checked against
//                a scoreboard queue filled when each miss is issued. A
//                hand-written sequence covers reset in the middle of a burst.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_il1_miss_fill_ctrl;

    localparam int ADDR_W  = 32;
    localparam int WAY_W   = 2;
    localparam int INDEX_W = 4;
    localparam int TAG_W   = 24;
    localparam int OFF_W   = 4;
    localparam int WORDS   = 4;
    localparam int MAXC    = 60;

    logic                clk;
    logic                rst_n;
    logic                PrRd;
    logic [ADDR_W-1:0]   Address;
    logic                Hit;
    logic [WAY_W-1:0]    Hit_way;
    logic [WAY_W-1:0]    LRU_replacement_proc;
    logic [WAY_W-1:0]    Blk_accessed;
    logic                Blk_accessed_vld;
    logic                Pr_done;
    logic                Bus_req;
    logic                Bus_grant;
    logic [ADDR_W-1:0]   Address_Com;
    logic                Mem_rd;
    logic                Mem_vld;
    logic [ADDR_W-1:0]   Data_Bus_Com;
    logic                Fill_we;
    logic [WAY_W-1:0]    Fill_way;
    logic [INDEX_W-1:0]  Fill_index;
    logic [1:0]          Fill_word;
    logic [ADDR_W-1:0]   Fill_data;
    logic                Tag_we;
    logic [TAG_W-1:0]    Fill_tag;

    il1_miss_fill_ctrl #(
        .ADDR_W (ADDR_W), .WAY_W (WAY_W), .INDEX_W (INDEX_W),
        .TAG_W  (TAG_W),  .OFF_W (OFF_W), .WORDS   (WORDS)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .PrRd                 (PrRd),
        .Address              (Address),
        .Hit                  (Hit),
        .Hit_way              (Hit_way),
        .LRU_replacement_proc (LRU_replacement_proc),
        .Blk_accessed         (Blk_accessed),
        .Blk_accessed_vld     (Blk_accessed_vld),
        .Pr_done              (Pr_done),
        .Bus_req              (Bus_req),
        .Bus_grant            (Bus_grant),
        .Address_Com          (Address_Com),
        .Mem_rd               (Mem_rd),
        .Mem_vld              (Mem_vld),
        .Data_Bus_Com         (Data_Bus_Com),
        .Fill_we              (Fill_we),
        .Fill_way             (Fill_way),
        .Fill_index           (Fill_index),
        .Fill_word            (Fill_word),
        .Fill_data            (Fill_data),
        .Tag_we               (Tag_we),
        .Fill_tag             (Fill_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction and its expected outcome
    typedef struct {
        logic        hit;
        logic [1:0]  hit_way;
        logic [31:0] addr;
        logic [1:0]  victim;
        int          gdelay;     // cycles without grant after the request
        int          gap_start;  // first cycle of a mid-burst grant loss
        int          gap_len;
        int          lru_chg;    // cycle at which LRU_replacement_proc changes
        logic [1:0]  lru_new;
        int          prrd_drop;  // cycle at which PrRd is released early
        int          exp_lat;    // cycles from request to Pr_done
        logic [1:0]  exp_way;    // expected Blk_accessed
    } vec_t;

    vec_t vecs[8];

    int n_pass = 0;
    int n_total = 0;
    int spurious = 0;
    int bus_bad = 0;
    logic [1:0] last_way = 2'd0;

    logic [39:0] q_fill[$];   // {way, index, word, data}
    logic [31:0] q_addr[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Scoreboard monitor: fill writes and burst addresses
    initial begin
        logic [39:0] e40;
        logic [31:0] e32;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (Fill_we) begin
                    if (q_fill.size() == 0) spurious++;
                    else begin
                        e40 = q_fill.pop_front();
                        check("fill_write", 64'({Fill_way, Fill_index, Fill_word, Fill_data}), 64'(e40));
                    end
                end
                if (Mem_rd && Mem_vld) begin
                    if (q_addr.size() == 0) spurious++;
                    else begin
                        e32 = q_addr.pop_front();
                        check("address_com", 64'(Address_Com), 64'(e32));
                    end
                end
                if (!Mem_rd && Address_Com != 32'd0) bus_bad++;
                if (Mem_rd && !Bus_grant) bus_bad++;
            end
        end
    end

    task automatic push_miss(input logic [31:0] addr, input logic [1:0] victim);
        logic [31:0] a;
        logic [1:0]  wb;
        for (int w = 0; w < WORDS; w++) begin
            wb = 2'(w);
            a  = {addr[31:4], wb, 2'b00};
            q_fill.push_back({victim, addr[7:4], wb, mem_word(a)});
            q_addr.push_back(a);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_ctrl"}, 64'({Blk_accessed, Blk_accessed_vld, Pr_done, Bus_req, Mem_rd,
                                  Fill_we, Tag_we, Fill_way, Fill_index, Fill_word}), 64'd0);
        check({nm, "_data"}, {Address_Com, Fill_data}, 64'd0);
        check({nm, "_tag"}, 64'(Fill_tag), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat, pd_cnt, vld_cnt, tag_cnt, breq, post_breq, post;
        logic [1:0]  blk;
        logic [31:0] inst;
        lat = -1; pd_cnt = 0; vld_cnt = 0; tag_cnt = 0; breq = 0; post_breq = 0; post = 0;
        blk = 'x; inst = 'x;
        spurious = 0; bus_bad = 0;
        @(posedge clk); #1;
        PrRd = 1'b1; Address = v.addr; Hit = v.hit; Hit_way = v.hit ? v.hit_way : 2'd1;
        LRU_replacement_proc = v.victim; Bus_grant = 1'b0; Mem_vld = 1'b0;
        if (!v.hit) push_miss(v.addr, v.victim);
        for (int j = 1; j <= MAXC; j++) begin
            @(posedge clk); #1;
            Bus_grant = (j > v.gdelay) && !(j >= v.gap_start && j < v.gap_start + v.gap_len);
            if (v.lru_chg != 0 && j >= v.lru_chg) LRU_replacement_proc = v.lru_new;
            if (v.prrd_drop != 0 && j >= v.prrd_drop) PrRd = 1'b0;
            if (lat >= 0) begin PrRd = 1'b0; Hit = 1'b0; end
            Mem_vld = 1'b1;
            #1 Data_Bus_Com = mem_word(Address_Com);
            @(negedge clk);
            if (Pr_done) begin pd_cnt++; if (lat < 0) lat = j; end
            if (Blk_accessed_vld) begin vld_cnt++; blk = Blk_accessed; end
            if (Tag_we) begin tag_cnt++; inst = {Fill_tag, Fill_way, Fill_index, 2'b00}; end
            if (lat < 0 || j == lat) begin
                if (Bus_req) breq++;
            end else if (Bus_req) post_breq++;
            if (lat >= 0) begin post++; if (post > 3) break; end
        end
        PrRd = 1'b0; Hit = 1'b0; Bus_grant = 1'b0; Mem_vld = 1'b0;
        if (!v.hit) last_way = v.victim;
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("pr_done_pulses", 64'(pd_cnt), 64'd1);
        check("blk_vld_pulses", 64'(vld_cnt), 64'd1);
        check("blk_accessed", 64'(blk), 64'(v.exp_way));
        check("tag_we_count", 64'(tag_cnt), v.hit ? 64'd0 : 64'd1);
        check("bus_req_used", 64'(breq != 0), 64'(!v.hit));
        check("no_new_request", 64'(post_breq), 64'd0);
        if (!v.hit) check("tag_install", 64'(inst), 64'({v.addr[31:8], v.victim, v.addr[7:4], 2'b00}));
        check("fill_way_hold", 64'(Fill_way), 64'(last_way));
        check("fills_outstanding", 64'(q_fill.size() + q_addr.size()), 64'd0);
        check("spurious_fill", 64'(spurious), 64'd0);
        check("bus_protocol", 64'(bus_bad), 64'd0);
        q_fill.delete(); q_addr.delete();
    endtask

    // Reset asserted in the middle of a burst
    task automatic reset_mid_fill();
        int tagseen, act;
        tagseen = 0; act = 0;
        @(posedge clk); #1;
        PrRd = 1'b1; Address = 32'h0000_3330; Hit = 1'b0; LRU_replacement_proc = 2'd1;
        Bus_grant = 1'b0; Mem_vld = 1'b0;
        push_miss(32'h0000_3330, 2'd1);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            Bus_grant = 1'b1; Mem_vld = 1'b1;
            #1 Data_Bus_Com = mem_word(Address_Com);
            if (j < 4) begin
                @(negedge clk);
                if (Tag_we) tagseen++;
            end
        end
        check("mid_fill_mem_rd", 64'(Mem_rd), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        PrRd = 1'b0; Bus_grant = 1'b0; Mem_vld = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("held_reset");
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            Bus_grant = 1'b1; Mem_vld = 1'b1;
            #1 Data_Bus_Com = mem_word(Address_Com);
            @(negedge clk);
            if (Tag_we) tagseen++;
            if (Bus_req || Mem_rd || Fill_we || Pr_done) act++;
        end
        Bus_grant = 1'b0; Mem_vld = 1'b0;
        check("idle_after_reset", 64'(act), 64'd0);
        check("no_tag_we_after_abort", 64'(tagseen), 64'd0);
        q_fill.delete(); q_addr.delete();
        last_way = 2'd0;
    endtask

    initial begin
        //           hit   hway  addr            vic   gd gs gl lc lnew  drop lat way
        vecs[0] = '{1'b1, 2'd2, 32'h0000_0040, 2'd0, 0, 0, 0, 0, 2'd0, 0,  1, 2'd2};
        vecs[1] = '{1'b0, 2'd0, 32'h0000_1234, 2'd3, 0, 0, 0, 0, 2'd0, 0,  7, 2'd3};
        vecs[2] = '{1'b1, 2'd0, 32'h0000_0088, 2'd1, 0, 0, 0, 0, 2'd0, 0,  1, 2'd0};
        vecs[3] = '{1'b0, 2'd0, 32'hABCD_EF50, 2'd0, 2, 0, 0, 0, 2'd0, 0,  9, 2'd0};
        vecs[4] = '{1'b0, 2'd0, 32'h0000_5678, 2'd2, 0, 4, 3, 0, 2'd0, 0, 10, 2'd2};
        vecs[5] = '{1'b0, 2'd0, 32'h1111_2220, 2'd1, 0, 0, 0, 3, 2'd0, 0,  7, 2'd1};
        vecs[6] = '{1'b0, 2'd0, 32'h2000_00F0, 2'd2, 0, 0, 0, 0, 2'd0, 1,  7, 2'd2};
        vecs[7] = '{1'b1, 2'd3, 32'h0000_0100, 2'd0, 0, 0, 0, 0, 2'd0, 0,  1, 2'd3};

        rst_n = 1'b0; PrRd = 1'b0; Address = '0; Hit = 1'b0; Hit_way = '0;
        LRU_replacement_proc = '0; Bus_grant = 1'b0; Mem_vld = 1'b0; Data_Bus_Com = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        reset_mid_fill();
        run_vec(vecs[0]);
        run_vec(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
